// File: rtl/lr_parser_param.sv
// ---------------------------------------------------------------------------
// lr_parser_param
//   Table-driven LR(1) shift/reduce parser core. The action, goto and
//   rule-length tables are written at run time through a table write port
//   while the parser is not busy. Tokens arrive over a valid/ready handshake.
//   Reduced rule indices leave over a second valid/ready handshake that
//   honours downstream backpressure.
//
// Optional feature (compile-time macro LR_PARSER_DEPTH_MON_EN):
//   When defined, adds output MAX_SP, the stack high-water mark. It is
//   cleared to 0 by RST, set to 1 by START and raised on every push.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   TBL_WE/SEL/ADDR/  table write port. SEL 0 action, 1 goto, 2 rule
//   TBL_WDATA         length, 3 ignored. ADDR = {state, column}.
//   START             begin a new parse (honoured when not busy)
//   I_VALID/I_READY/  token input handshake and token kind
//   I_KIND
//   O_VALID/O_READY/  reduced-rule output handshake and rule index
//   O_RULE
//   BUSY              parse in progress
//   ACCEPT, ERROR     sticky status (never both set)
//   ERR_CODE          0 none, 1 syntax, 2 stack overflow, 3 stack underflow
// ---------------------------------------------------------------------------
module lr_parser_param #(
  parameter int unsigned STATE_W     = 6,
  parameter int unsigned TOKEN_W     = 4,
  parameter int unsigned RULE_W      = 4,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned STACK_DEPTH = 64,
  localparam int unsigned SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       TBL_WE,
  input  logic [1:0]                 TBL_SEL,
  input  logic [STATE_W+TOKEN_W-1:0] TBL_ADDR,
  input  logic [STATE_W+1:0]         TBL_WDATA,
  input  logic                       START,
  input  logic                       I_VALID,
  output logic                       I_READY,
  input  logic [TOKEN_W-1:0]         I_KIND,
  output logic                       O_VALID,
  input  logic                       O_READY,
  output logic [RULE_W-1:0]          O_RULE,
  output logic                       BUSY,
  output logic                       ACCEPT,
  output logic                       ERROR,
  output logic [1:0]                 ERR_CODE
`ifdef LR_PARSER_DEPTH_MON_EN
  ,
  output logic [SP_W-1:0]            MAX_SP
`endif
);

  localparam int unsigned ADDR_W    = STATE_W + TOKEN_W;
  localparam int unsigned ACT_W     = STATE_W + 2;
  localparam int unsigned TBL_DEPTH = 1 << ADDR_W;
  localparam int unsigned NUM_RULES = 1 << RULE_W;
  localparam int unsigned IDX_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    K_ERROR  = 2'd0,
    K_SHIFT  = 2'd1,
    K_REDUCE = 2'd2,
    K_ACCEPT = 2'd3
  } kind_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_LOOKUP,
    S_ACT,
    S_POP,
    S_GOTO,
    S_EMIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] EC_SYNTAX    = 2'd1;
  localparam logic [1:0] EC_OVERFLOW  = 2'd2;
  localparam logic [1:0] EC_UNDERFLOW = 2'd3;

  state_t               state;
  logic [SP_W-1:0]      sp;
  logic [STATE_W-1:0]   stack [STACK_DEPTH];
  logic [TOKEN_W-1:0]   tok_q;
  logic [RULE_W-1:0]    rule_q;
  logic [LEN_W-1:0]     cnt_q;

  logic [ACT_W-1:0]     action_ram [TBL_DEPTH];
  logic [STATE_W-1:0]   goto_ram   [TBL_DEPTH];
  logic [LEN_W-1:0]     len_ram    [NUM_RULES];
  logic [ACT_W-1:0]     action_q;
  logic [STATE_W-1:0]   goto_q;

  logic [IDX_W-1:0]     top_idx_c;
  logic [IDX_W-1:0]     push_idx_c;
  logic [STATE_W-1:0]   top_c;
  logic [SP_W-1:0]      sp_inc_c;
  kind_t                act_kind_c;
  logic [STATE_W-1:0]   act_val_c;
  logic [RULE_W-1:0]    act_rule_c;
  logic [LEN_W-1:0]     act_len_c;
  logic                 tbl_open_c;
  logic                 full_c;

  // Stack pointer decode: top of stack and next free slot
  assign top_idx_c  = IDX_W'(sp - SP_W'(1));
  assign push_idx_c = IDX_W'(sp);
  assign top_c      = stack[top_idx_c];
  assign sp_inc_c   = sp + SP_W'(1);
  assign full_c     = (sp == SP_W'(STACK_DEPTH));

  // Fields of the action entry fetched in LOOKUP
  assign act_kind_c = kind_t'(action_q[ACT_W-1 -: 2]);
  assign act_val_c  = action_q[STATE_W-1:0];
  assign act_rule_c = act_val_c[RULE_W-1:0];
  // Rule length is looked up in the same cycle as the action decode so the
  // underflow check and POP count are ready at ACT; the table is tiny.
  assign act_len_c  = len_ram[act_rule_c];

  assign tbl_open_c = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  // Table write port, closed while a parse is running
  always_ff @(posedge CLK) begin
    if (TBL_WE && tbl_open_c) begin
      case (TBL_SEL)
        2'd0:    action_ram[TBL_ADDR] <= TBL_WDATA;
        2'd1:    goto_ram[TBL_ADDR]   <= TBL_WDATA[STATE_W-1:0];
        2'd2:    len_ram[TBL_ADDR[RULE_W-1:0]] <= TBL_WDATA[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Synchronous table reads: action in LOOKUP, goto in GOTO
  always_ff @(posedge CLK) begin
    if (state == S_LOOKUP) begin
      action_q <= action_ram[{top_c, tok_q}];
    end
    if (state == S_GOTO) begin
      goto_q <= goto_ram[{top_c, TOKEN_W'(rule_q)}];
    end
  end

  // Parser FSM with registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      sp       <= '0;
      tok_q    <= '0;
      rule_q   <= '0;
      cnt_q    <= '0;
      I_READY  <= 1'b0;
      O_VALID  <= 1'b0;
      O_RULE   <= '0;
      BUSY     <= 1'b0;
      ACCEPT   <= 1'b0;
      ERROR    <= 1'b0;
      ERR_CODE <= 2'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (START) begin
            stack[0] <= '0;
            sp       <= SP_W'(1);
            ACCEPT   <= 1'b0;
            ERROR    <= 1'b0;
            ERR_CODE <= 2'd0;
            I_READY  <= 1'b1;
            BUSY     <= 1'b1;
            state    <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (I_VALID) begin
            tok_q   <= I_KIND;
            I_READY <= 1'b0;
            state   <= S_LOOKUP;
          end
        end

        S_LOOKUP: state <= S_ACT;

        S_ACT: begin
          case (act_kind_c)
            K_SHIFT: begin
              if (full_c) begin
                ERROR    <= 1'b1;
                ERR_CODE <= EC_OVERFLOW;
                BUSY     <= 1'b0;
                state    <= S_ERR;
              end else begin
                stack[push_idx_c] <= act_val_c;
                sp      <= sp_inc_c;
                I_READY <= 1'b1;
                state   <= S_WAIT;
              end
            end
            K_REDUCE: begin
              rule_q <= act_rule_c;
              cnt_q  <= act_len_c;
              // Popping every entry would leave no state to take the goto from
              if (32'(act_len_c) >= 32'(sp)) begin
                ERROR    <= 1'b1;
                ERR_CODE <= EC_UNDERFLOW;
                BUSY     <= 1'b0;
                state    <= S_ERR;
              end else if (act_len_c != '0) begin
                state <= S_POP;
              end else begin
                state <= S_GOTO;
              end
            end
            K_ACCEPT: begin
              ACCEPT <= 1'b1;
              BUSY   <= 1'b0;
              state  <= S_DONE;
            end
            default: begin
              ERROR    <= 1'b1;
              ERR_CODE <= EC_SYNTAX;
              BUSY     <= 1'b0;
              state    <= S_ERR;
            end
          endcase
        end

        S_POP: begin
          sp    <= sp - SP_W'(1);
          cnt_q <= cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state <= S_GOTO;
          end
        end

        S_GOTO: begin
          O_VALID <= 1'b1;
          O_RULE  <= rule_q;
          state   <= S_EMIT;
        end

        // Goto state is pushed on the handshake; the latched token is then
        // looked up again against the new top of stack.
        S_EMIT: begin
          if (O_READY) begin
            stack[push_idx_c] <= goto_q;
            sp      <= sp_inc_c;
            O_VALID <= 1'b0;
            state   <= S_LOOKUP;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LR_PARSER_DEPTH_MON_EN
  logic push_c;

  assign push_c = ((state == S_ACT) && (act_kind_c == K_SHIFT) && !full_c) ||
                  ((state == S_EMIT) && O_READY);

  // Stack high-water mark
  always_ff @(posedge CLK) begin
    if (RST) begin
      MAX_SP <= '0;
    end else if (tbl_open_c && START) begin
      MAX_SP <= SP_W'(1);
    end else if (push_c && (sp_inc_c > MAX_SP)) begin
      MAX_SP <= sp_inc_c;
    end
  end
`endif

endmodule
